// File: rtl/mac_encode_pipe_if.sv
// Handshake bundle for mac_encode_pipe: request vector in, encoded lowest-set-bit result out.
interface mac_encode_pipe_if #(
   parameter int W  = 16,
   parameter int IW = 4
);
   logic [W-1:0]  in_vec;
   logic          in_vld;
   logic          in_rdy;
   logic [IW-1:0] out_idx;
   logic          out_zero;
   logic          out_multi;
   logic          out_vld;
   logic          out_rdy;

   // Producer/consumer side of the block (drives in_*, consumes out_*).
   modport master (
      output in_vec, in_vld, out_rdy,
      input  in_rdy, out_idx, out_zero, out_multi, out_vld
   );

   // The encoder itself.
   modport slave (
      input  in_vec, in_vld, out_rdy,
      output in_rdy, out_idx, out_zero, out_multi, out_vld
   );
endinterface

// File: rtl/mac_encode_pipe.sv
// Two-stage pipelined priority encoder (lowest set bit wins) with valid/ready flow control.
// Optional multi-hot detector compiled in when MAC_ENCODE_MULTI_CHECK_EN is defined.
module mac_encode_pipe #(
   parameter int W  = 16,
   parameter int IW = 4
) (
   input  logic              clk,
   input  logic              rst,
   mac_encode_pipe_if.slave  bus
);

   function automatic logic [IW-1:0] f_lowest_idx(input logic [W-1:0] vec);
      logic [IW-1:0] idx;
      idx = '0;
      // Scan downward so the lowest-numbered set bit is the last one written.
      for (int i = W - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = IW'(i);
         end
      end
      return idx;
   endfunction

`ifdef MAC_ENCODE_MULTI_CHECK_EN
   function automatic logic f_multi_hot(input logic [W-1:0] vec);
      return |(vec & (vec - {{(W-1){1'b0}}, 1'b1}));
   endfunction
`endif

   logic          r_rdy_en;
   logic          r_s1_full;
   logic [W-1:0]  r_s1_vec;
   logic          r_s2_vld;
   logic [IW-1:0] r_s2_idx;
   logic          r_s2_zero;

   logic          w_s1_adv;
   logic          w_in_rdy;
   logic          w_in_xfer;
   logic          w_out_xfer;
   logic [IW-1:0] w_enc_idx;
   logic          w_enc_zero;

   // Handshake qualifiers; in_rdy stays low until the first edge after reset release.
   always_comb begin
      w_s1_adv   = r_s1_full && (!r_s2_vld || bus.out_rdy);
      w_in_rdy   = r_rdy_en && (!r_s1_full || w_s1_adv);
      w_in_xfer  = bus.in_vld && w_in_rdy;
      w_out_xfer = r_s2_vld && bus.out_rdy;
   end

   // Encode the S1 contents ahead of the S2 register.
   always_comb begin
      w_enc_idx  = f_lowest_idx(r_s1_vec);
      w_enc_zero = ~|r_s1_vec;
   end

   // Ready-enable: set one cycle after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rdy_en <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
      end
   end

   // Stage 1: capture the raw request vector.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1_full <= 1'b0;
         r_s1_vec  <= '0;
      end else if (w_in_xfer) begin
         r_s1_full <= 1'b1;
         r_s1_vec  <= bus.in_vec;
      end else if (w_s1_adv) begin
         r_s1_full <= 1'b0;
      end else begin
         r_s1_full <= r_s1_full;
      end
   end

   // Stage 2: hold the encoded result until the downstream takes it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s2_vld  <= 1'b0;
         r_s2_idx  <= '0;
         r_s2_zero <= 1'b0;
      end else if (w_s1_adv) begin
         r_s2_vld  <= 1'b1;
         r_s2_idx  <= w_enc_idx;
         r_s2_zero <= w_enc_zero;
      end else if (w_out_xfer) begin
         r_s2_vld  <= 1'b0;
      end else begin
         r_s2_vld  <= r_s2_vld;
      end
   end

`ifdef MAC_ENCODE_MULTI_CHECK_EN
   logic r_s2_multi;
   logic w_enc_multi;

   // Multi-hot flag computed from S1, travelling alongside the index.
   always_comb begin
      w_enc_multi = f_multi_hot(r_s1_vec);
   end

   // Stage 2 copy of the multi-hot flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s2_multi <= 1'b0;
      end else if (w_s1_adv) begin
         r_s2_multi <= w_enc_multi;
      end else begin
         r_s2_multi <= r_s2_multi;
      end
   end

   assign bus.out_multi = r_s2_multi;
`else
   assign bus.out_multi = 1'b0;
`endif

   assign bus.in_rdy   = w_in_rdy;
   assign bus.out_vld  = r_s2_vld;
   assign bus.out_idx  = r_s2_idx;
   assign bus.out_zero = r_s2_zero;

   mac_encode_pipe_chk #(.IW(IW)) u_chk (
      .clk      (clk),
      .rst      (rst),
      .out_vld  (r_s2_vld),
      .out_rdy  (bus.out_rdy),
      .out_idx  (r_s2_idx),
      .out_zero (r_s2_zero)
   );

endmodule

// Output-side protocol properties of the encoder.
module mac_encode_pipe_chk #(
   parameter int IW = 4
) (
   input logic          clk,
   input logic          rst,
   input logic          out_vld,
   input logic          out_rdy,
   input logic [IW-1:0] out_idx,
   input logic          out_zero
);
   a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
      (out_vld && !out_rdy) |=> (out_vld && $stable(out_idx) && $stable(out_zero)));

   a_zero_idx: assert property (@(posedge clk) disable iff (!rst)
      (out_vld && out_zero) |-> (out_idx == '0));
endmodule

// File: tb/tb_mac_encode_pipe.sv
// Directed bench for mac_encode_pipe: table of single vectors, hand-written pipeline sequences,
// and a one-hot sweep through a W=4096 instance.
module tb_mac_encode_pipe;

`ifdef MAC_ENCODE_MULTI_CHECK_EN
   localparam logic MC = 1'b1;
`else
   localparam logic MC = 1'b0;
`endif

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   mac_encode_pipe_if #(.W(16),   .IW(4))  bus   ();
   mac_encode_pipe_if #(.W(4096), .IW(12)) bus_w ();

   mac_encode_pipe #(.W(16),   .IW(4))  u_dut   (.clk(clk), .rst(rst), .bus(bus));
   mac_encode_pipe #(.W(4096), .IW(12)) u_dut_w (.clk(clk), .rst(rst), .bus(bus_w));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] vec;
      logic [3:0]  idx;
      logic        zero;
      logic        multi;
   } rec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input rec_t r);
      bit got;
      @(negedge clk);
      bus.in_vec  = r.vec;
      bus.in_vld  = 1'b1;
      bus.out_rdy = 1'b1;
      #1 chk("tbl_in_rdy", 32'(bus.in_rdy), 32'd1);
      @(posedge clk);
      #1 bus.in_vld = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
         @(negedge clk);
         if (bus.out_vld) got = 1'b1;
      end
      if (!got) begin
         chk("tbl_timeout", 32'd0, 32'd1);
      end else begin
         chk($sformatf("tbl_idx_%04h", r.vec), 32'(bus.out_idx), 32'(r.idx));
         chk($sformatf("tbl_zero_%04h", r.vec), 32'(bus.out_zero), 32'(r.zero));
         chk($sformatf("tbl_multi_%04h", r.vec), 32'(bus.out_multi), 32'(r.multi & MC));
      end
      @(posedge clk);
   endtask

   rec_t        tbl[9];
   int          got_q[$];
   bit          acc;
   logic [4095:0] vw;
   int          k;
   int          ek;

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b0;
      bus.in_vec = '0;   bus.in_vld = 1'b0;   bus.out_rdy = 1'b1;
      bus_w.in_vec = '0; bus_w.in_vld = 1'b0; bus_w.out_rdy = 1'b1;

      tbl[0] = '{16'h0001, 4'd0,  1'b0, 1'b0};
      tbl[1] = '{16'h0020, 4'd5,  1'b0, 1'b0};
      tbl[2] = '{16'h8000, 4'd15, 1'b0, 1'b0};
      tbl[3] = '{16'h0000, 4'd0,  1'b1, 1'b0};
      tbl[4] = '{16'h0A00, 4'd9,  1'b0, 1'b1};
      tbl[5] = '{16'hFFFF, 4'd0,  1'b0, 1'b1};
      tbl[6] = '{16'h8001, 4'd0,  1'b0, 1'b1};
      tbl[7] = '{16'hC000, 4'd14, 1'b0, 1'b1};
      tbl[8] = '{16'h0100, 4'd8,  1'b0, 1'b0};

      // Reset state
      @(negedge clk); @(negedge clk);
      chk("rst_out_vld",   32'(bus.out_vld),   32'd0);
      chk("rst_in_rdy",    32'(bus.in_rdy),    32'd0);
      chk("rst_out_idx",   32'(bus.out_idx),   32'd0);
      chk("rst_out_zero",  32'(bus.out_zero),  32'd0);
      chk("rst_out_multi", 32'(bus.out_multi), 32'd0);
      rst = 1'b1;
      #1 chk("rel_in_rdy_early", 32'(bus.in_rdy), 32'd0);
      @(negedge clk);
      chk("rel_in_rdy", 32'(bus.in_rdy), 32'd1);
      chk("rel_in_rdy_w", 32'(bus_w.in_rdy), 32'd1);

      // Latency: accepted at edge 0, out_vld visible after edge 1
      bus.in_vec = 16'h0020; bus.in_vld = 1'b1;
      @(posedge clk);
      #1 bus.in_vld = 1'b0;
      @(negedge clk);
      chk("lat_vld_c1", 32'(bus.out_vld), 32'd0);
      @(negedge clk);
      chk("lat_vld_c2", 32'(bus.out_vld), 32'd1);
      chk("lat_idx",    32'(bus.out_idx), 32'd5);
      chk("lat_zero",   32'(bus.out_zero), 32'd0);
      @(negedge clk);
      chk("lat_drain", 32'(bus.out_vld), 32'd0);

      // Table of single vectors
      for (int i = 0; i < 9; i++) run_vec(tbl[i]);

      // Back-to-back 0x0001, 0x8000, 0x0000
      @(negedge clk);
      bus.out_rdy = 1'b1;
      bus.in_vec = 16'h0001; bus.in_vld = 1'b1;
      @(negedge clk);
      chk("b2b_vld0", 32'(bus.out_vld), 32'd0);
      bus.in_vec = 16'h8000;
      @(negedge clk);
      chk("b2b_vld1", 32'(bus.out_vld), 32'd1);
      chk("b2b_idx1", 32'(bus.out_idx), 32'd0);
      chk("b2b_zero1", 32'(bus.out_zero), 32'd0);
      bus.in_vec = 16'h0000;
      @(negedge clk);
      bus.in_vld = 1'b0;
      chk("b2b_vld2", 32'(bus.out_vld), 32'd1);
      chk("b2b_idx2", 32'(bus.out_idx), 32'd15);
      chk("b2b_zero2", 32'(bus.out_zero), 32'd0);
      @(negedge clk);
      chk("b2b_vld3", 32'(bus.out_vld), 32'd1);
      chk("b2b_idx3", 32'(bus.out_idx), 32'd0);
      chk("b2b_zero3", 32'(bus.out_zero), 32'd1);
      @(negedge clk);
      chk("b2b_drain", 32'(bus.out_vld), 32'd0);

      // Backpressure: out_rdy low for 5 cycles while streaming 0x0004, 0x0010, 0x0040
      bus.out_rdy = 1'b0;
      bus.in_vec = 16'h0004; bus.in_vld = 1'b1;
      #1 chk("bp_rdy0", 32'(bus.in_rdy), 32'd1);
      @(negedge clk);
      bus.in_vec = 16'h0010;
      #1 chk("bp_rdy1", 32'(bus.in_rdy), 32'd1);
      @(negedge clk);
      bus.in_vec = 16'h0040;
      #1 chk("bp_rdy2", 32'(bus.in_rdy), 32'd0);
      @(negedge clk);
      #1 chk("bp_rdy3", 32'(bus.in_rdy), 32'd0);
      chk("bp_hold_idx", 32'(bus.out_idx), 32'd2);
      @(negedge clk);
      #1 chk("bp_rdy4", 32'(bus.in_rdy), 32'd0);
      chk("bp_hold_vld", 32'(bus.out_vld), 32'd1);
      @(negedge clk);
      bus.out_rdy = 1'b1;
      got_q.delete();
      for (int c = 0; c < 12; c++) begin
         #1;
         if (bus.out_vld) got_q.push_back(int'(bus.out_idx));
         acc = bus.in_vld && bus.in_rdy;
         @(posedge clk);
         if (acc) #1 bus.in_vld = 1'b0;
         @(negedge clk);
      end
      chk("bp_count", 32'(got_q.size()), 32'd3);
      if (got_q.size() == 3) begin
         chk("bp_out0", 32'(got_q[0]), 32'd2);
         chk("bp_out1", 32'(got_q[1]), 32'd4);
         chk("bp_out2", 32'(got_q[2]), 32'd6);
      end

      // Reset mid-operation with both stages full
      bus.out_rdy = 1'b0;
      bus.in_vec = 16'h0003; bus.in_vld = 1'b1;
      @(negedge clk);
      bus.in_vec = 16'h0005;
      @(negedge clk);
      bus.in_vld = 1'b0;
      chk("mr_full_vld", 32'(bus.out_vld), 32'd1);
      #2 rst = 1'b0;
      #1 chk("mr_vld_now", 32'(bus.out_vld), 32'd0);
      chk("mr_in_rdy", 32'(bus.in_rdy), 32'd0);
      chk("mr_idx", 32'(bus.out_idx), 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      bus.out_rdy = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("mr_stale_%0d", c), 32'(bus.out_vld), 32'd0);
      end
      run_vec('{16'h0100, 4'd8, 1'b0, 1'b0});

      // One-hot sweep on the W=4096 instance
      k = 0;
      ek = 0;
      for (int c = 0; c < 4300 && ek < 4096; c++) begin
         @(negedge clk);
         if (bus_w.out_vld) begin
            chk("sweep_idx", 32'(bus_w.out_idx), 32'(ek));
            ek++;
         end
         if (k < 4096) begin
            vw = '0;
            vw[k] = 1'b1;
            bus_w.in_vec = vw;
            bus_w.in_vld = 1'b1;
         end else begin
            bus_w.in_vld = 1'b0;
         end
         #1 acc = bus_w.in_vld && bus_w.in_rdy;
         @(posedge clk);
         if (acc) k++;
      end
      bus_w.in_vld = 1'b0;
      chk("sweep_count", 32'(ek), 32'd4096);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mac_encode_pipe.md
MAC_ENCODE_PIPE -- requirements
Module: mac_encode_pipe

Interface
REQ-001 SHALL provide parameter W, default 16, width of the input request vector (power of two, 4..4096).
REQ-002 SHALL provide parameter IW, default 4, index width, equal to log2(W).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_vec  input  W  request vector; bit i set means index i is requested.
REQ-006 SHALL have port in_vld  input  1  in_vec is valid this cycle.
REQ-007 SHALL have port in_rdy  output  1  block accepts in_vec this cycle.
REQ-008 SHALL have port out_idx  output  IW  encoded index of the lowest set bit.
REQ-009 SHALL have port out_zero  output  1  accepted vector had no bit set.
REQ-010 SHALL have port out_multi  output  1  accepted vector had more than one bit set (see Configuration).
REQ-011 SHALL have port out_vld  output  1  out_idx/out_zero/out_multi are valid.
REQ-012 SHALL have port out_rdy  input  1  downstream accepts the output this cycle.

Function
REQ-013 SHALL be the inverse of the mac_DECODE family: for a one-hot input with bit k set, out_idx SHALL equal k.
REQ-014 SHALL transfer input when in_vld and in_rdy are both 1 at a rising edge; output transfers when out_vld and out_rdy are both 1.
REQ-015 SHALL have two register stages: S1 captures in_vec; S2 holds the encoded result; accept-to-out_vld latency is exactly 2 cycles when out_rdy stays 1.
REQ-016 SHALL advance S1 into S2 when S1 is full and (S2 empty or out_rdy=1).
REQ-017 SHALL drive in_rdy = !S1_full || S1 advancing this cycle (combinational on out_rdy); sustained throughput 1 vector/cycle with out_rdy=1.
REQ-018 SHALL hold S2 outputs stable while out_vld=1 and out_rdy=0; no data loss or duplication under any out_rdy pattern.
REQ-019 SHALL select the lowest-numbered set bit when several bits are set (priority: bit 0 highest).
REQ-020 SHALL produce out_zero=1 and out_idx=0 for an all-zero vector; out_zero=0 otherwise.
REQ-021 SHALL never drop out_vld without a completed output transfer.

Reset
REQ-022 SHALL on rst=0 asynchronously clear S1 and S2 valid flags: out_vld=0, out_idx=0, out_zero=0, out_multi=0.
REQ-023 SHALL drive in_rdy=1 one cycle after reset release (both stages empty); in_rdy is 0 while rst=0.
REQ-024 SHALL discard any in-flight vectors on reset assertion mid-operation; no output is produced for them after release.

Configuration
REQ-025 SHALL compile the multi-hot detector only when macro MAC_ENCODE_MULTI_CHECK_EN is defined.
REQ-026 SHALL, with MAC_ENCODE_MULTI_CHECK_EN defined, set out_multi=1 alongside the result of any vector with two or more set bits, out_multi=0 otherwise.
REQ-027 SHALL, without MAC_ENCODE_MULTI_CHECK_EN, tie out_multi to constant 0 and contain no detector logic; all other behaviour identical.

Verification
REQ-028 SHALL cover: W=16, out_rdy=1, in_vec=0x0020 accepted cycle 0 -> out_vld=1 at cycle 2, out_idx=5, out_zero=0.
REQ-029 SHALL cover: back-to-back 0x0001,0x8000,0x0000 with out_rdy=1 -> out_idx 0,15,0 on consecutive cycles, out_zero=1 only on third.
REQ-030 SHALL cover: in_vec=0x0A00 -> out_idx=9; out_multi=1 with MAC_ENCODE_MULTI_CHECK_EN, 0 without.
REQ-031 SHALL cover: out_rdy=0 for 5 cycles while streaming 0x0004,0x0010,0x0040 -> in_rdy falls after 2 accepts, outputs 2,4,6 delivered in order once out_rdy=1.
REQ-032 SHALL cover: rst pulsed low while S1 and S2 full -> out_vld=0 immediately, no stale output after release, next input 0x0100 yields out_idx=8.
REQ-033 SHALL cover: exhaustive one-hot sweep, W=4096, k=0..4095 through mac_DECODE_4096U then this block -> out_idx=k for all k.
